// File: rtl/ram_bus_sequencer_if.sv
// Requester handshakes plus memory-side bus and strobes of the ram_bus_sequencer.
// master is the sequencer; slave is the CPU/DMA requesters together with the memory.
interface ram_bus_sequencer_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_half;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        dma_req;
  logic [15:0] dma_src;
  logic [15:0] dma_dst;
  logic [7:0]  dma_len;
  logic        dma_done;
  logic        busy;
  logic [15:0] data_bus;
  logic [15:0] db_out;
  logic        set_address;
  logic        read;
  logic        write;
  logic        half_mode;
  logic        set_transfer_addr;
  logic        data_transfer;

  modport master (
    input  cpu_req, cpu_we, cpu_half, cpu_addr, cpu_wdata,
    input  dma_req, dma_src, dma_dst, dma_len, data_bus,
    output cpu_rdata, cpu_done, dma_done, busy, db_out,
    output set_address, read, write, half_mode, set_transfer_addr, data_transfer
  );

  modport slave (
    output cpu_req, cpu_we, cpu_half, cpu_addr, cpu_wdata,
    output dma_req, dma_src, dma_dst, dma_len, data_bus,
    input  cpu_rdata, cpu_done, dma_done, busy, db_out,
    input  set_address, read, write, half_mode, set_transfer_addr, data_transfer
  );
endinterface

// File: rtl/ram_bus_sequencer.sv
// Turns CPU single-word accesses and DMA block copies into memory strobe sequences.
// CPU wins contention unless DMA has waited through STARVE_LIMIT consecutive CPU grants.
module ram_bus_sequencer #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  ram_bus_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ACCESS, XSRC, XDST, XPULSE, XGAP, DONE
  } state_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  len_q, len_d;
  logic        is_dma_q, is_dma_d;
  logic        we_q, we_d;
  logic        half_q, half_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cpu_win;

  assign cpu_win = bus.cpu_req && (!bus.dma_req || streak_q != LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      is_dma_q    <= 1'b0;
      we_q        <= 1'b0;
      half_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      is_dma_q    <= is_dma_d;
      we_q        <= we_d;
      half_q      <= half_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    is_dma_d    = is_dma_q;
    we_d        = we_q;
    half_d      = half_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_win) begin
          state_d  = ADDR;
          is_dma_d = 1'b0;
          we_d     = bus.cpu_we;
          half_d   = bus.cpu_half;
          addr_d   = bus.cpu_addr;
          wdata_d  = bus.cpu_wdata;
          // Streak only grows while DMA is actually being held off.
          if (bus.dma_req) streak_d = (streak_q == LIMIT) ? LIMIT : streak_q + 3'd1;
          else             streak_d = '0;
        end else if (bus.dma_req) begin
          state_d  = XSRC;
          is_dma_d = 1'b1;
          src_d    = bus.dma_src;
          dst_d    = bus.dma_dst;
          len_d    = bus.dma_len;
          streak_d = '0;
        end
      end
      ADDR: state_d = ACCESS;
      ACCESS: begin
        if (!we_q) rdata_d = bus.data_bus;
        state_d = DONE;
      end
      XSRC: state_d = XDST;
      XDST: begin
        remaining_d = len_q;
        state_d     = (len_q == 8'd0) ? DONE : XPULSE;
      end
      XPULSE: begin
        remaining_d = remaining_q - 8'd1;
        state_d     = XGAP;
      end
      XGAP: state_d = (remaining_q == 8'd0) ? DONE : XPULSE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a pure decode of registered state so reset clears them immediately.
  always_comb begin
    bus.set_address       = 1'b0;
    bus.read              = 1'b0;
    bus.write             = 1'b0;
    bus.half_mode         = 1'b0;
    bus.set_transfer_addr = 1'b0;
    bus.data_transfer     = 1'b0;
    bus.db_out            = '0;
    case (state_q)
      ADDR: begin
        bus.set_address = 1'b1;
        bus.half_mode   = half_q;
        bus.db_out      = addr_q;
      end
      ACCESS: begin
        bus.read      = !we_q;
        bus.write     = we_q;
        bus.half_mode = half_q;
        bus.db_out    = we_q ? wdata_q : 16'h0000;
      end
      XSRC: begin
        bus.set_transfer_addr = 1'b1;
        bus.db_out            = src_q;
      end
      XDST: begin
        bus.set_address = 1'b1;
        bus.db_out      = dst_q;
      end
      XPULSE:  bus.data_transfer = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.cpu_done  = (state_q == DONE) && !is_dma_q;
  assign bus.dma_done  = (state_q == DONE) && is_dma_q;
  assign bus.cpu_rdata = rdata_q;
endmodule
